// File: rtl/mont_mult_host_port_if.sv
// Host-side bus bundle for the Fp^2 half Montgomery multiplier host port:
// input digit stream, operand memory write port, multiplier control,
// result memory read port and output digit stream.
interface mont_mult_host_port_if #(
  parameter int RADIX               = 24,
  parameter int INPUT_MEM_DEPTH_LOG = 5,
  parameter int RES_MEM_DEPTH_LOG   = 4,
  parameter int RES_MEM_WIDTH       = 2 * RADIX
);
  logic                           in_valid;
  logic                           in_ready;
  logic [RADIX-1:0]               in_data;
  logic [4:0]                     op_wr_en;
  logic [INPUT_MEM_DEPTH_LOG-1:0] op_wr_addr;
  logic [RADIX-1:0]               op_wr_din;
  logic                           mult_start;
  logic                           mult_done;
  logic                           mult_busy;
  logic                           mult_mem_res_rd_en;
  logic [RES_MEM_DEPTH_LOG-1:0]   mult_mem_res_rd_addr;
  logic [RES_MEM_WIDTH-1:0]       mult_mem_res_dout;
  logic                           out_valid;
  logic                           out_ready;
  logic [RADIX-1:0]               out_data;
  logic                           out_last;
  logic                           busy;

  // Host port side: drives memory writes, multiplier control and the output stream.
  modport master (
    input  in_valid, in_data, mult_done, mult_busy, mult_mem_res_dout, out_ready,
    output in_ready, op_wr_en, op_wr_addr, op_wr_din, mult_start,
           mult_mem_res_rd_en, mult_mem_res_rd_addr, out_valid, out_data, out_last, busy
  );

  // Environment side: digit source, multiplier/result memory and digit sink.
  modport slave (
    output in_valid, in_data, mult_done, mult_busy, mult_mem_res_dout, out_ready,
    input  in_ready, op_wr_en, op_wr_addr, op_wr_din, mult_start,
           mult_mem_res_rd_en, mult_mem_res_rd_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/mont_mult_host_port.sv
// Host port for the pipelined Fp^2 half Montgomery multiplier: loads the five
// operand memories from a digit stream, starts the multiplier, waits for done,
// then streams the packed two-digit result entries out LSD first.
module mont_mult_host_port #(
  parameter int RADIX               = 24,
  parameter int WIDTH_REAL          = 32,
  parameter int WIDTH               = ((WIDTH_REAL + 1) / 2) * 2,
  parameter int INPUT_MEM_DEPTH_LOG = $clog2(WIDTH_REAL),
  parameter int RES_MEM_DEPTH       = WIDTH / 2,
  parameter int RES_MEM_DEPTH_LOG   = $clog2(RES_MEM_DEPTH),
  parameter int RES_MEM_WIDTH       = 2 * RADIX
) (
  input logic                   clk,
  input logic                   rst,
  mont_mult_host_port_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RD_REQ, S_RD_LEFT, S_RD_RIGHT
  } state_t;

  localparam logic [INPUT_MEM_DEPTH_LOG-1:0] LAST_ADDR = INPUT_MEM_DEPTH_LOG'(WIDTH_REAL - 1);
  localparam logic [RES_MEM_DEPTH_LOG:0]     LAST_DIG  = (RES_MEM_DEPTH_LOG + 1)'(WIDTH_REAL - 1);

  state_t                         state;
  state_t                         state_nxt;
  logic [INPUT_MEM_DEPTH_LOG-1:0] dig_cnt;
  logic [2:0]                     op_sel;
  logic [RES_MEM_DEPTH_LOG-1:0]   ent_cnt;
  logic                           accept;
  logic                           out_fire;
  logic                           last_operand_digit;
  logic                           left_is_last;
  logic                           right_is_last;
  logic                           rd_vld_p1;
  logic [RES_MEM_WIDTH-1:0]       hold_p2;
  logic [RES_MEM_WIDTH-1:0]       entry;

  assign accept             = bus.in_valid & bus.in_ready;
  assign out_fire           = bus.out_valid & bus.out_ready;
  assign last_operand_digit = (dig_cnt == LAST_ADDR) && (op_sel == 3'd4);
  assign left_is_last       = ({ent_cnt, 1'b0} == LAST_DIG);
  assign right_is_last      = ({ent_cnt, 1'b1} == LAST_DIG);
  // The entry is presented straight from memory in the cycle its read data
  // arrives, so only one bubble separates entries; afterwards it comes from hold.
  assign entry              = rd_vld_p1 ? bus.mult_mem_res_dout : hold_p2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_LOAD;
      S_LOAD:     if (accept && last_operand_digit) state_nxt = S_START;
      S_START:    state_nxt = S_WAIT;
      S_WAIT:     if (bus.mult_done) state_nxt = S_RD_REQ;
      S_RD_REQ:   if (bus.mult_mem_res_rd_en) state_nxt = S_RD_LEFT;
      S_RD_LEFT:  if (out_fire) state_nxt = left_is_last ? S_IDLE : S_RD_RIGHT;
      S_RD_RIGHT: if (out_fire) state_nxt = right_is_last ? S_IDLE : S_RD_REQ;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs; everything is forced low while rst is held so an abort is immediate.
  always_comb begin
    bus.in_ready             = 1'b0;
    bus.op_wr_en             = '0;
    bus.op_wr_addr           = '0;
    bus.op_wr_din            = '0;
    bus.mult_start           = 1'b0;
    bus.mult_mem_res_rd_en   = 1'b0;
    bus.mult_mem_res_rd_addr = '0;
    bus.out_valid            = 1'b0;
    bus.out_data             = '0;
    bus.out_last             = 1'b0;
    bus.busy                 = 1'b0;
    if (!rst) begin
      bus.busy = (state != S_IDLE);
      case (state)
        S_IDLE, S_LOAD: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            bus.op_wr_en   = 5'b00001 << op_sel;
            bus.op_wr_addr = dig_cnt;
            bus.op_wr_din  = bus.in_data;
          end
        end
        S_START: bus.mult_start = 1'b1;
        S_RD_REQ: begin
          // The multiplier owns the result address while it runs.
          bus.mult_mem_res_rd_en   = ~bus.mult_busy;
          bus.mult_mem_res_rd_addr = ent_cnt;
        end
        S_RD_LEFT: begin
          bus.out_valid = 1'b1;
          bus.out_data  = entry[2*RADIX-1:RADIX];
          bus.out_last  = left_is_last;
        end
        S_RD_RIGHT: begin
          bus.out_valid = 1'b1;
          bus.out_data  = entry[RADIX-1:0];
          bus.out_last  = right_is_last;
        end
        default: ;
      endcase
    end
  end

  // Digit/operand/entry counters and read-return flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_cnt   <= '0;
      op_sel    <= '0;
      ent_cnt   <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= bus.mult_mem_res_rd_en;
      if (accept) begin
        if (dig_cnt == LAST_ADDR) begin
          dig_cnt <= '0;
          op_sel  <= (op_sel == 3'd4) ? 3'd0 : op_sel + 3'd1;
        end else begin
          dig_cnt <= dig_cnt + INPUT_MEM_DEPTH_LOG'(1);
        end
      end
      if (state == S_RD_LEFT && out_fire && left_is_last) ent_cnt <= '0;
      if (state == S_RD_RIGHT && out_fire)
        ent_cnt <= right_is_last ? '0 : ent_cnt + RES_MEM_DEPTH_LOG'(1);
    end
  end

  // Stage p2: hold the result entry the cycle after its read returns.
  always_ff @(posedge clk) begin
    if (rd_vld_p1) hold_p2 <= bus.mult_mem_res_dout;
  end

endmodule

// File: tb/tb_mont_mult_host_port.sv
// Bench for mont_mult_host_port: two instances (4-digit and 3-digit operands,
// 8-bit digits) driven with directed jobs, a per-cycle compare against a
// transaction-level model, and literal expected digit tables.
module tb_mont_mult_host_port;

  localparam int PH_LOAD = 0;
  localparam int PH_COMP = 1;
  localparam int PH_READ = 2;
  localparam int DONE_DLY = 50;
  localparam int WR_EN_LIT   [0:19] = '{1,1,1,1,2,2,2,2,4,4,4,4,8,8,8,8,16,16,16,16};
  localparam int WR_ADDR_LIT [0:19] = '{0,1,2,3,0,1,2,3,0,1,2,3,0,1,2,3,0,1,2,3};

  logic clk = 1'b0;
  logic rst;
  logic model_rst;
  always #5 clk = ~clk;

  mont_mult_host_port_if #(.RADIX(8), .INPUT_MEM_DEPTH_LOG(2), .RES_MEM_DEPTH_LOG(1)) if4 ();
  mont_mult_host_port_if #(.RADIX(8), .INPUT_MEM_DEPTH_LOG(2), .RES_MEM_DEPTH_LOG(1)) if3 ();

  mont_mult_host_port #(.RADIX(8), .WIDTH_REAL(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  mont_mult_host_port #(.RADIX(8), .WIDTH_REAL(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  int errors = 0;
  int checks = 0;

  // Model state, indexed by unit (0: 4-digit, 1: 3-digit).
  int          wr_of     [2] = '{4, 3};
  int          phase     [2];
  int          wr_cnt    [2];
  int          out_idx   [2];
  int          rd_cnt    [2];
  int          bub       [2];
  int          load_no   [2];
  bit          start_due [2];
  bit          prev_stall[2];
  logic [7:0]  prev_data [2];
  logic        prev_last [2];
  logic [7:0]  lit_out   [2][4];
  logic [15:0] res_mem   [2][2];
  int          cnt4, cnt3;

  // Multiplier and result memory stand-ins (own reset, unaffected by rst).
  always @(posedge clk) begin
    if (model_rst) begin
      if4.mult_busy <= 1'b0; if4.mult_done <= 1'b0; cnt4 <= 0;
    end else begin
      if4.mult_done <= 1'b0;
      if (if4.mult_start) begin if4.mult_busy <= 1'b1; cnt4 <= DONE_DLY - 1; end
      else if (if4.mult_busy) begin
        if (cnt4 == 1) begin if4.mult_done <= 1'b1; if4.mult_busy <= 1'b0; end
        else cnt4 <= cnt4 - 1;
      end
    end
    if4.mult_mem_res_dout <= if4.mult_mem_res_rd_en ? res_mem[0][if4.mult_mem_res_rd_addr]
                                                    : 16'($urandom);
  end

  always @(posedge clk) begin
    if (model_rst) begin
      if3.mult_busy <= 1'b0; if3.mult_done <= 1'b0; cnt3 <= 0;
    end else begin
      if3.mult_done <= 1'b0;
      if (if3.mult_start) begin if3.mult_busy <= 1'b1; cnt3 <= DONE_DLY - 1; end
      else if (if3.mult_busy) begin
        if (cnt3 == 1) begin if3.mult_done <= 1'b1; if3.mult_busy <= 1'b0; end
        else cnt3 <= cnt3 - 1;
      end
    end
    if3.mult_mem_res_dout <= if3.mult_mem_res_rd_en ? res_mem[1][if3.mult_mem_res_rd_addr]
                                                    : 16'($urandom);
  end

  task automatic chk(input int u, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", u, name, act, exp, $time);
    end
  endtask

  task automatic check_port(
    input int u, input logic rs,
    input logic in_valid, input logic in_ready, input logic [7:0] in_data,
    input logic [4:0] wr_en, input logic [1:0] wr_addr, input logic [7:0] wr_din,
    input logic start, input logic done, input logic mbusy,
    input logic rd_en, input logic out_valid, input logic out_ready,
    input logic [7:0] out_data, input logic out_last, input logic busy);
    int k;
    int wr;
    logic [15:0] ent;
    logic [7:0] exp_d;
    wr = wr_of[u];
    if (rs) begin
      chk(u, "reset_outputs", {in_ready, wr_en, start, rd_en, out_valid, out_last, busy, out_data, wr_addr, wr_din}, 32'd0);
      phase[u] = PH_LOAD; wr_cnt[u] = 0; out_idx[u] = 0; rd_cnt[u] = 0; bub[u] = 0;
      start_due[u] = 0; prev_stall[u] = 0;
      return;
    end
    chk(u, "in_ready", in_ready, phase[u] == PH_LOAD);
    chk(u, "busy", busy, !(phase[u] == PH_LOAD && wr_cnt[u] == 0));
    chk(u, "mult_start", start, start_due[u]);
    start_due[u] = 0;
    if (rd_en) begin
      chk(u, "rd_en_while_busy", mbusy, 1'b0);
      rd_cnt[u]++;
    end
    if (phase[u] != PH_READ) begin
      chk(u, "rd_en_outside_read", rd_en, 1'b0);
      chk(u, "out_valid_outside_read", out_valid, 1'b0);
    end
    if (in_valid && in_ready) begin
      k = wr_cnt[u];
      chk(u, "op_wr_en", wr_en, 32'(1 << (k / wr)));
      chk(u, "op_wr_addr", wr_addr, 32'(k % wr));
      chk(u, "op_wr_din", wr_din, in_data);
      if (u == 0 && load_no[0] == 0) begin
        chk(u, "op_wr_en_lit", wr_en, WR_EN_LIT[k]);
        chk(u, "op_wr_addr_lit", wr_addr, WR_ADDR_LIT[k]);
        chk(u, "op_wr_din_lit", wr_din, 32'(k));
      end
      wr_cnt[u]++;
      if (wr_cnt[u] == 5 * wr) begin
        phase[u] = PH_COMP; wr_cnt[u] = 0; start_due[u] = 1; load_no[u]++;
      end
    end else begin
      chk(u, "op_wr_en_idle", wr_en, 32'd0);
    end
    if (phase[u] == PH_COMP && done) begin
      phase[u] = PH_READ; out_idx[u] = 0; rd_cnt[u] = 0; bub[u] = 0; prev_stall[u] = 0;
    end else if (phase[u] == PH_READ) begin
      if (prev_stall[u]) chk(u, "hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last[u], prev_data[u]});
      if (bub[u] == 1) begin chk(u, "bubble", out_valid, 1'b0); bub[u] = 2; end
      else if (bub[u] == 2) begin chk(u, "after_bubble", out_valid, 1'b1); bub[u] = 0; end
      prev_stall[u] = out_valid && !out_ready;
      prev_data[u]  = out_data;
      prev_last[u]  = out_last;
      if (out_valid && out_ready) begin
        k = out_idx[u];
        ent = res_mem[u][k / 2];
        exp_d = (k % 2 == 0) ? ent[15:8] : ent[7:0];
        chk(u, "out_data", out_data, exp_d);
        chk(u, "out_data_lit", out_data, lit_out[u][k]);
        chk(u, "out_last", out_last, k == wr - 1);
        out_idx[u]++;
        if (k == wr - 1) begin
          chk(u, "rd_en_count", rd_cnt[u], (wr + 1) / 2);
          phase[u] = PH_LOAD; wr_cnt[u] = 0; prev_stall[u] = 0;
        end else if (k % 2 == 1) begin
          bub[u] = 1;
        end
      end
    end
  endtask

  // Compare both units against the model on every falling edge.
  always @(negedge clk) begin
    check_port(0, rst, if4.in_valid, if4.in_ready, if4.in_data, if4.op_wr_en, if4.op_wr_addr,
               if4.op_wr_din, if4.mult_start, if4.mult_done, if4.mult_busy, if4.mult_mem_res_rd_en,
               if4.out_valid, if4.out_ready, if4.out_data, if4.out_last, if4.busy);
    check_port(1, rst, if3.in_valid, if3.in_ready, if3.in_data, if3.op_wr_en, if3.op_wr_addr,
               if3.op_wr_din, if3.mult_start, if3.mult_done, if3.mult_busy, if3.mult_mem_res_rd_en,
               if3.out_valid, if3.out_ready, if3.out_data, if3.out_last, if3.busy);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_in(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin if4.in_valid = v; if4.in_data = d; end
    else        begin if3.in_valid = v; if3.in_data = d; end
  endtask

  task automatic load(input int u, input int base, input bit toggle);
    int n;
    int k;
    int cyc;
    logic v;
    n = 5 * wr_of[u]; k = 0; cyc = 0;
    while (k < n) begin
      if (cyc > 400) begin
        $display("FAIL u%0d load_timeout: accepted %0d of %0d", u, k, n);
        $fatal(1, "load timeout");
      end
      v = !(toggle && (cyc % 2 == 1));
      drive_in(u, v, 8'(base + k));
      @(negedge clk);
      if (v && ((u == 0) ? if4.in_ready : if3.in_ready)) k++;
      @(posedge clk); #1;
      cyc++;
    end
    drive_in(u, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int u);
    int c;
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (((u == 0) ? if4.busy : if3.busy) && c < 500);
    if ((u == 0) ? if4.busy : if3.busy) begin
      $display("FAIL u%0d idle_timeout: busy still 1 after %0d cycles", u, c);
      $fatal(1, "idle timeout");
    end
    tick();
  endtask

  initial begin
    int c;
    rst = 1'b1; model_rst = 1'b1;
    drive_in(0, 1'b0, 8'h00); drive_in(1, 1'b0, 8'h00);
    if4.out_ready = 1'b1; if3.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0; model_rst = 1'b0;
    repeat (2) tick();

    // Job A: continuous load 0x00..0x13, result A1 A2 | A3 A4.
    res_mem[0][0] = 16'hA1A2; res_mem[0][1] = 16'hA3A4;
    lit_out[0] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    load(0, 0, 1'b0);
    wait_idle(0);

    // Job B: in_valid toggling, then out_ready low 5 cycles while A2 is presented.
    load(0, 8'h40, 1'b1);
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (!(if4.out_valid && if4.out_data == 8'hA1) && c < 200);
    if (c >= 200) begin
      $display("FAIL u0 first_digit_timeout: no 0xA1 within %0d cycles", c);
      $fatal(1, "readout timeout");
    end
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    repeat (5) tick();
    if4.out_ready = 1'b1;
    wait_idle(0);

    // Job C: abort with a one-cycle reset mid-WAIT; the late done is ignored.
    load(0, 8'h60, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (60) tick();

    // Job D: fresh load completes normally.
    res_mem[0][0] = 16'hC1C2; res_mem[0][1] = 16'hC3C4;
    lit_out[0] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load(0, 8'h80, 1'b0);
    wait_idle(0);

    // Odd operand length: padding digit of the last entry is dropped.
    res_mem[1][0] = 16'h1122; res_mem[1][1] = 16'h3300;
    lit_out[1] = '{8'h11, 8'h22, 8'h33, 8'h00};
    load(1, 8'h20, 1'b0);
    wait_idle(1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
